alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter W, default 4, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  request from requester 0/1; held high until the matching done pulse.
REQ-005 op0, op1  input  3 each  opcode; held stable while the matching req is high.
REQ-006 a0, b0, a1, b1  input  W each  operands; held stable while the matching req is high.
REQ-007 done0, done1  output  1 each  one-cycle pulse: result valid for that requester.
REQ-008 result  output  W  registered result, valid while any done is high.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 gnt  output  1  index of the currently or last granted requester.

Function
REQ-011 The block SHALL share one combinational W-bit ALU between the two requesters.
- Opcodes: 000 AND, 001 OR, 010 NOT a (bitwise), 011 XOR, 100 ADD, 101 SUB (a-b), 110 pass a, 111 pass b.
REQ-012 ADD and SUB SHALL wrap modulo 2^W; the carry/borrow is dropped unless ALU_ARB_FLAGS_EN is defined.
REQ-013 The FSM SHALL have the states IDLE, LATCH, EXEC and RESP, encoded in 2 bits.
REQ-014 IDLE: if any req is high, select the winner, set gnt, go to LATCH; otherwise stay in IDLE.
REQ-015 LATCH: capture the winner's op, a and b into internal registers; go to EXEC.
REQ-016 EXEC: register the ALU output into result; go to RESP.
REQ-017 RESP: pulse the winner's done for exactly one cycle; go to IDLE.
REQ-018 Latency SHALL be 3 cycles from the IDLE cycle sampling req to the done cycle; throughput SHALL be 1 op per 4 cycles.
REQ-019 Arbitration SHALL be round-robin: with both req high in IDLE, grant the requester not equal to last_gnt.
- last_gnt updates on each grant; reset value 1, so requester 0 wins the first tie.
REQ-020 With a single req high, that requester SHALL be granted regardless of last_gnt.
REQ-021 Operand changes after LATCH SHALL NOT affect the in-flight result.
REQ-022 done0 and done1 SHALL never be high in the same cycle.
REQ-023 result SHALL hold its value until the next EXEC.
REQ-024 A req that drops before grant SHALL be ignored; a req that drops after grant SHALL NOT abort the operation (done still pulses).

Reset
REQ-025 rst high at any clock edge SHALL force state IDLE, result 0, done0/done1 0, busy 0, gnt 0, last_gnt 1, internal operand registers 0.
REQ-026 Reset during LATCH, EXEC or RESP SHALL discard the operation with no done pulse; the requester re-arbitrates after reset.

Configuration
REQ-027 Macro ALU_ARB_FLAGS_EN defined: add outputs zero (1 bit, result==0) and carry (1 bit, ADD carry-out / SUB borrow, 0 for logic ops).
- Both are registered in EXEC alongside result; reset value 0.
REQ-028 ALU_ARB_FLAGS_EN undefined: the zero and carry ports and their logic SHALL be absent.

Structure
REQ-029 Shared package alu_pkg SHALL hold the opcode constants and the FSM state encodings.
REQ-030 The combinational ALU SHALL be a separate sub-module alu_core (inputs op, a, b; outputs y and carry), instantiated once.
- Bitwise ops inside alu_core SHALL reuse the team's existing W-bit bitwise gate modules.
REQ-031 The arbiter/FSM and the operand/result registers SHALL reside in alu_arbiter.

Verification
REQ-032 Reset, then req0=1, op0=100, a0=4'h7, b0=4'h9 -> done0 pulses 3 cycles after the IDLE sample, result=4'h0; with FLAGS_EN, carry=1 and zero=1.
REQ-033 req0 and req1 both high from reset, each holding until its done -> grants alternate 0,1,0,1; no cycle has done0 and done1 both high.
REQ-034 req1=1, op1=010, a1=4'b1010 -> done1 pulses, result=4'b0101, gnt=1.
REQ-035 req0 with op0=101, a0=4'h2, b0=4'h5; change a0 to 4'hF in EXEC -> result=4'hD (in-flight value unaffected); with FLAGS_EN, carry=1.
REQ-036 rst asserted during EXEC -> no done pulse and result=0; after release a still-held req0 completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and FSM state encodings for the ALU arbiter
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] OP_AND    = 3'b000;
  localparam logic [2:0] OP_OR     = 3'b001;
  localparam logic [2:0] OP_NOT_A  = 3'b010;
  localparam logic [2:0] OP_XOR    = 3'b011;
  localparam logic [2:0] OP_ADD    = 3'b100;
  localparam logic [2:0] OP_SUB    = 3'b101;
  localparam logic [2:0] OP_PASS_A = 3'b110;
  localparam logic [2:0] OP_PASS_B = 3'b111;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - two-requester ALU bus; zero/carry present only with ALU_ARB_FLAGS_EN
interface alu_arbiter_if #(
  parameter int W = 4
);

  logic         req0;
  logic         req1;
  logic [2:0]   op0;
  logic [2:0]   op1;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         done0;
  logic         done1;
  logic [W-1:0] result;
  logic         busy;
  logic         gnt;

`ifdef ALU_ARB_FLAGS_EN
  logic         zero;
  logic         carry;

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1,
    input  done0, done1, result, busy, gnt, zero, carry
  );

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1,
    output done0, done1, result, busy, gnt, zero, carry
  );
`else
  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1,
    input  done0, done1, result, busy, gnt
  );

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1,
    output done0, done1, result, busy, gnt
  );
`endif

endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational W-bit ALU shared by both requesters
module alu_core
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         carry
);

  logic [W-1:0] and_y;
  logic [W-1:0] or_y;
  logic [W-1:0] xor_y;
  logic [W-1:0] not_y;
  logic [W:0]   sum;
  logic [W:0]   diff;

  bw_and #(.W(W)) u_and (.a(a), .b(b), .y(and_y));
  bw_or  #(.W(W)) u_or  (.a(a), .b(b), .y(or_y));
  bw_xor #(.W(W)) u_xor (.a(a), .b(b), .y(xor_y));
  bw_not #(.W(W)) u_not (.a(a), .y(not_y));

  // The extra top bit is the carry-out for ADD and the borrow (a < b) for SUB
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_AND:    y = and_y;
      OP_OR:     y = or_y;
      OP_NOT_A:  y = not_y;
      OP_XOR:    y = xor_y;
      OP_ADD:    {carry, y} = sum;
      OP_SUB:    {carry, y} = diff;
      OP_PASS_A: y = a;
      OP_PASS_B: y = b;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/bw_and.sv
// rtl/bw_and.sv - W-bit bitwise AND gate
module bw_and #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = a & b;

endmodule

// File: rtl/bw_not.sv
// rtl/bw_not.sv - W-bit bitwise inverter
module bw_not #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = ~a;

endmodule

// File: rtl/bw_or.sv
// rtl/bw_or.sv - W-bit bitwise OR gate
module bw_or #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = a | b;

endmodule

// File: rtl/bw_xor.sv
// rtl/bw_xor.sv - W-bit bitwise XOR gate
module bw_xor #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
// Optional zero/carry result flags are built when ALU_ARB_FLAGS_EN is defined.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  state_t       state;
  state_t       state_nxt;
  logic         gnt_q;
  logic         gnt_nxt;
  logic         last_gnt_q;
  logic [2:0]   op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] result_q;
  logic [W-1:0] alu_y;

`ifdef ALU_ARB_FLAGS_EN
  logic         alu_carry;
  logic         zero_q;
  logic         carry_q;
`else
  logic         carry_unused;
`endif

  alu_core #(.W(W)) u_core (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .y     (alu_y),
`ifdef ALU_ARB_FLAGS_EN
    .carry (alu_carry)
`else
    .carry (carry_unused)
`endif
  );

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_q;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the requester not served last wins; a lone request always wins
          if (bus.req0 && bus.req1) begin
            gnt_nxt = ~last_gnt_q;
          end else begin
            gnt_nxt = bus.req1;
          end
          state_nxt = LATCH;
        end
      end
      LATCH:   state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
`ifdef ALU_ARB_FLAGS_EN
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      gnt_q <= gnt_nxt;
      if (state == IDLE && state_nxt == LATCH) begin
        last_gnt_q <= gnt_nxt;
      end
      // Operands are frozen here so later requester-side changes cannot leak in
      if (state == LATCH) begin
        op_q <= gnt_q ? bus.op1 : bus.op0;
        a_q  <= gnt_q ? bus.a1  : bus.a0;
        b_q  <= gnt_q ? bus.b1  : bus.b0;
      end
      if (state == EXEC) begin
        result_q <= alu_y;
`ifdef ALU_ARB_FLAGS_EN
        zero_q   <= (alu_y == '0);
        carry_q  <= alu_carry;
`endif
      end
    end
  end

  assign bus.done0  = (state == RESP) && !gnt_q;
  assign bus.done1  = (state == RESP) &&  gnt_q;
  assign bus.busy   = (state != IDLE);
  assign bus.gnt    = gnt_q;
  assign bus.result = result_q;
`ifdef ALU_ARB_FLAGS_EN
  assign bus.zero   = zero_q;
  assign bus.carry  = carry_q;
`endif

endmodule
